// File: rtl/tmds_encoder_serializer.sv
// Three-lane DVI TMDS 8b/10b encoder with running-disparity DC balance, followed by
// 10:1 LSB-first serializers; pixel timing is recovered from the pixel_clk register.
module tmds_encoder_serializer (
   input  logic       fast_clk,
   input  logic       n_rst,
   input  logic       pixel_clk,
   input  logic       active_video,
   input  logic       h_sync,
   input  logic       v_sync,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   output logic [2:0] tmds_data_p,
   output logic [2:0] tmds_data_n
);

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   // Transition-minimising stage: q_m[8] records XOR (1) or XNOR (0).
   function automatic logic [8:0] transition_min(input logic [7:0] d);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] qm;
      n1       = popcount8(d);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      qm       = '0;
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8]    = ~use_xnor;
      return qm;
   endfunction

   function automatic logic [9:0] ctrl_token(input logic [1:0] c);
      logic [9:0] tok;
      case (c)
         2'b00:   tok = CTRL_00;
         2'b01:   tok = CTRL_01;
         2'b10:   tok = CTRL_10;
         default: tok = CTRL_11;
      endcase
      return tok;
   endfunction

   // Returns {next cnt, 10-bit word}; cnt is the signed ones-minus-zeros tally.
   function automatic logic [14:0] dc_balance(input logic [8:0] qm, input logic [4:0] cnt);
      logic signed [4:0] cur;
      logic signed [4:0] n1;
      logic signed [4:0] n0;
      logic signed [4:0] nxt;
      logic        [9:0] word;
      logic              q8;
      logic        [7:0] data;
      q8   = qm[8];
      data = qm[7:0];
      n1   = $signed({1'b0, popcount8(data)});
      n0   = 5'sd8 - n1;
      cur  = $signed(cnt);
      if ((cur == 5'sd0) || (n1 == n0)) begin
         word = {~q8, q8, q8 ? data : ~data};
         nxt  = q8 ? (cur + (n1 - n0)) : (cur + (n0 - n1));
      end else if (((cur > 5'sd0) && (n1 > n0)) || ((cur < 5'sd0) && (n0 > n1))) begin
         word = {1'b1, q8, ~data};
         nxt  = cur + (q8 ? 5'sd2 : 5'sd0) + (n0 - n1);
      end else begin
         word = {1'b0, q8, data};
         nxt  = cur - (q8 ? 5'sd0 : 5'sd2) + (n1 - n0);
      end
      return {nxt, word};
   endfunction

   logic             pix_q, pix_d;
   logic             rise, fall;

   logic [2:0][7:0]  pix_data_q, pix_data_d;
   logic             de_cap_q, de_cap_d;
   logic [1:0]       ctl_cap_q, ctl_cap_d;
   logic             cap_vld_q, cap_vld_d;

   logic [2:0][8:0]  qm_q, qm_d;
   logic             de_s1_q, de_s1_d;
   logic [1:0]       ctl_s1_q, ctl_s1_d;
   logic             s1_vld_q, s1_vld_d;

   logic [2:0][9:0]  word_q, word_d;
   logic [2:0][4:0]  cnt_q, cnt_d;
   logic [2:0][9:0]  shift_q, shift_d;

   assign rise = pixel_clk & ~pix_q;
   assign fall = ~pixel_clk & pix_q;

   // Mid-period capture and stage 1 (transition minimisation).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      pix_d      = pixel_clk;
      pix_data_d = pix_data_q;
      de_cap_d   = de_cap_q;
      ctl_cap_d  = ctl_cap_q;
      cap_vld_d  = fall;
      qm_d       = qm_q;
      de_s1_d    = de_s1_q;
      ctl_s1_d   = ctl_s1_q;
      s1_vld_d   = cap_vld_q;
      if (fall) begin
         pix_data_d = {red, green, blue};
         de_cap_d   = active_video;
         ctl_cap_d  = {v_sync, h_sync};
      end
      if (cap_vld_q) begin
         for (int ch = 0; ch < 3; ch++) qm_d[ch] = transition_min(pix_data_q[ch]);
         de_s1_d  = de_cap_q;
         ctl_s1_d = ctl_cap_q;
      end
   end

   // Stage 2: one update per captured pixel, so cnt never advances on idle bit-clock cycles.
   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (s1_vld_q) begin
         for (int ch = 0; ch < 3; ch++) begin
            if (!de_s1_q) begin
               word_d[ch] = ctrl_token((ch == 0) ? ctl_s1_q : 2'b00);
               cnt_d[ch]  = '0;
            end else begin
               {cnt_d[ch], word_d[ch]} = dc_balance(qm_q[ch], cnt_q[ch]);
            end
         end
      end
   end

   // Serializer: an early rise simply overwrites the unsent bits.
   always_comb begin
      for (int ch = 0; ch < 3; ch++) begin
         shift_d[ch] = rise ? word_q[ch] : {1'b0, shift_q[ch][9:1]};
      end
   end

   always_ff @(posedge fast_clk or negedge n_rst) begin
      if (!n_rst) begin
         // NOTE: the word registers reset to the 00 control token, not zero, so the
         // first character after reset is a legal TMDS symbol.
         pix_q      <= 1'b0;
         pix_data_q <= '0;
         de_cap_q   <= 1'b0;
         ctl_cap_q  <= '0;
         cap_vld_q  <= 1'b0;
         qm_q       <= '0;
         de_s1_q    <= 1'b0;
         ctl_s1_q   <= '0;
         s1_vld_q   <= 1'b0;
         word_q     <= {3{CTRL_00}};
         cnt_q      <= '0;
         shift_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         pix_q      <= pix_d;
         pix_data_q <= pix_data_d;
         de_cap_q   <= de_cap_d;
         ctl_cap_q  <= ctl_cap_d;
         cap_vld_q  <= cap_vld_d;
         qm_q       <= qm_d;
         de_s1_q    <= de_s1_d;
         ctl_s1_q   <= ctl_s1_d;
         s1_vld_q   <= s1_vld_d;
         word_q     <= word_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
      end
   end

   assign tmds_data_p = {shift_q[2][0], shift_q[1][0], shift_q[0][0]};
   assign tmds_data_n = ~tmds_data_p;

endmodule

// File: tb/tb_tmds_encoder_serializer.sv
// Scoreboard bench: each driven pixel pushes its expected TMDS words; each rise
// closes the previously serialized character and compares it against the queue head.
module tb_tmds_encoder_serializer;

   localparam logic [9:0] TOK_00 = 10'b1101010100;
   localparam logic [9:0] TOK_01 = 10'b0010101011;
   localparam logic [9:0] TOK_10 = 10'b0101010100;
   localparam logic [9:0] TOK_11 = 10'b1010101011;

   logic       fast_clk = 1'b0;
   logic       n_rst;
   logic       pixel_clk;
   logic       active_video;
   logic       h_sync;
   logic       v_sync;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;
   logic [2:0] tmds_data_p;
   logic [2:0] tmds_data_n;

   always #5 fast_clk = ~fast_clk;

   tmds_encoder_serializer dut (
      .fast_clk     (fast_clk),
      .n_rst        (n_rst),
      .pixel_clk    (pixel_clk),
      .active_video (active_video),
      .h_sync       (h_sync),
      .v_sync       (v_sync),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .tmds_data_p  (tmds_data_p),
      .tmds_data_n  (tmds_data_n)
   );

   typedef struct {
      logic [2:0][9:0] w;
      bit              de;
      bit              line;
      bit              chk_const;
      logic [9:0]      cw0;
      int              cdisp;
   } exp_t;

   exp_t             sb_q[$];
   int               n_tests = 0;
   int               n_fail  = 0;
   int               m_cnt[3];
   int               rdisp[3];
   int               line_disp[3];
   logic [2:0][31:0] col;
   int               ncol;
   bit               loaded;
   int               n_bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  tag, $signed(got), got, $signed(exp), exp);
      end
   endtask

   // Reference encoder written from the DVI formulation with integer disparity.
   function automatic logic [9:0] ref_encode(input int ch, input logic [7:0] d,
                                             input bit de, input logic [1:0] ctl);
      int         ones, n1, n0;
      bit         xn;
      logic [8:0] qm;
      logic [9:0] w;
      if (!de) begin
         m_cnt[ch] = 0;
         case (ctl)
            2'b00:   return TOK_00;
            2'b01:   return TOK_01;
            2'b10:   return TOK_10;
            default: return TOK_11;
         endcase
      end
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      xn    = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm    = '0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
      n0 = 8 - n1;
      if (m_cnt[ch] == 0 || n1 == n0) begin
         if (qm[8]) begin
            w = {2'b01, qm[7:0]};
            m_cnt[ch] += n1 - n0;
         end else begin
            w = {2'b10, ~qm[7:0]};
            m_cnt[ch] += n0 - n1;
         end
      end else if ((m_cnt[ch] > 0 && n1 > n0) || (m_cnt[ch] < 0 && n0 > n1)) begin
         w = {1'b1, qm[8], ~qm[7:0]};
         m_cnt[ch] += 2 * int'(qm[8]) + n0 - n1;
      end else begin
         w = {1'b0, qm[8], qm[7:0]};
         m_cnt[ch] += -2 * int'(!qm[8]) + n1 - n0;
      end
      return w;
   endfunction

   task automatic push_pixel(input bit de, input logic [1:0] ctl, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b, input bit line,
                             input bit cc, input logic [9:0] cw0, input int cdisp);
      exp_t e;
      e.w[2]      = ref_encode(2, r, de, 2'b00);
      e.w[1]      = ref_encode(1, g, de, 2'b00);
      e.w[0]      = ref_encode(0, b, de, ctl);
      e.de        = de;
      e.line      = line;
      e.chk_const = cc;
      e.cw0       = cw0;
      e.cdisp     = cdisp;
      sb_q.push_back(e);
   endtask

   task automatic sample_bits();
      if (ncol < 32) begin
         for (int ch = 0; ch < 3; ch++) col[ch][ncol] = tmds_data_p[ch];
         ncol++;
      end
      if (tmds_data_n !== ~tmds_data_p) n_bad++;
   endtask

   // Closes the character serialized since the previous rise.
   task automatic finalize();
      exp_t        e;
      int          nb;
      logic [31:0] mask;
      if (!loaded) begin
         for (int ch = 0; ch < 3; ch++) check($sformatf("lane%0d_pre_load_idle", ch), col[ch], 0);
      end else begin
         check("sb_not_empty", {31'd0, sb_q.size() > 0}, 1);
         if (sb_q.size() > 0) begin
            e    = sb_q.pop_front();
            nb   = (ncol < 10) ? ncol : 10;
            mask = (32'd1 << nb) - 32'd1;
            for (int ch = 0; ch < 3; ch++) begin
               check($sformatf("lane%0d_word", ch), col[ch] & mask, {22'd0, e.w[ch]} & mask);
               if (ncol > 10) check($sformatf("lane%0d_idle_tail", ch), col[ch] >> 10, 0);
               if (!e.de) rdisp[ch] = 0;
               else for (int k = 0; k < nb; k++) rdisp[ch] += col[ch][k] ? 1 : -1;
               if (e.line) line_disp[ch] = rdisp[ch];
            end
            if (e.chk_const) begin
               check("lane0_const_word", {22'd0, col[0][9:0]}, {22'd0, e.cw0});
               check("lane0_running_disp", rdisp[0], e.cdisp);
            end
            check("data_n_complement", n_bad, 0);
         end
      end
      col    = '0;
      ncol   = 0;
      n_bad  = 0;
      loaded = 1'b1;
   endtask

   task automatic apply_reset();
      exp_t e;
      n_rst     = 1'b0;
      pixel_clk = 1'b0;
      #1;
      check("rst_data_p", {29'd0, tmds_data_p}, 32'd0);
      check("rst_data_n", {29'd0, tmds_data_n}, 32'd7);
      repeat (3) @(negedge fast_clk);
      n_rst  = 1'b1;
      sb_q.delete();
      m_cnt  = '{0, 0, 0};
      rdisp  = '{0, 0, 0};
      col    = '0;
      ncol   = 0;
      n_bad  = 0;
      loaded = 1'b0;
      e.w         = {3{TOK_00}};
      e.de        = 1'b0;
      e.line      = 1'b0;
      e.chk_const = 1'b1;
      e.cw0       = TOK_00;
      e.cdisp     = 0;
      sb_q.push_back(e);
   endtask

   // One pixel period of len fast_clk cycles, starting with a pixel_clk rise.
   task automatic run_pixel(input bit de, input logic [1:0] ctl, input logic [7:0] r,
                            input logic [7:0] g, input logic [7:0] b, input int len,
                            input bit line, input bit cc, input logic [9:0] cw0,
                            input int cdisp, input int rst_at);
      int hi;
      hi = (len < 10) ? 3 : 5;
      for (int i = 0; i < len; i++) begin
         @(negedge fast_clk);
         sample_bits();
         if (i == rst_at) begin
            apply_reset();
            return;
         end
         if (i == 0) begin
            finalize();
            active_video = de;
            h_sync       = ctl[0];
            v_sync       = ctl[1];
            red          = r;
            green        = g;
            blue         = b;
            push_pixel(de, ctl, r, g, b, line, cc, cw0, cdisp);
            pixel_clk = 1'b1;
         end else begin
            pixel_clk = (i < hi);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] pats [8] = '{8'hFF, 8'h10, 8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h01, 8'h7E};
      n_rst        = 1'b1;
      pixel_clk    = 1'b0;
      active_video = 1'b0;
      h_sync       = 1'b0;
      v_sync       = 1'b0;
      red          = '0;
      green        = '0;
      blue         = '0;
      @(negedge fast_clk);
      apply_reset();

      // Blanking with h_sync, then the blue=0 disparity sequence and its reset by blanking.
      run_pixel(0, 2'b01, 8'h00, 8'h00, 8'h00, 10, 0, 1, TOK_01, 0, -1);
      run_pixel(1, 2'b00, 8'h5A, 8'hC3, 8'h00, 10, 0, 1, 10'h100, -8, -1);
      run_pixel(1, 2'b00, 8'h11, 8'hEE, 8'h00, 10, 0, 1, 10'h3FF, 2, -1);
      run_pixel(1, 2'b00, 8'hFF, 8'h80, 8'h00, 10, 0, 1, 10'h100, -6, -1);
      run_pixel(0, 2'b10, 8'h00, 8'h00, 8'h00, 10, 0, 1, TOK_10, 0, -1);
      run_pixel(1, 2'b00, 8'h33, 8'h44, 8'h00, 10, 0, 1, 10'h100, -8, -1);
      run_pixel(0, 2'b11, 8'h00, 8'h00, 8'h00, 10, 0, 1, TOK_11, 0, -1);
      foreach (pats[i]) run_pixel(1, 2'b00, ~pats[i], pats[7-i], pats[i], 10, 0, 0, '0, 0, -1);

      // One random active line.
      run_pixel(0, 2'b00, 8'h00, 8'h00, 8'h00, 10, 0, 0, '0, 0, -1);
      for (int i = 0; i < 640; i++) begin
         run_pixel(1, 2'b00, 8'($urandom), 8'($urandom), 8'($urandom), 10, 1, 0, '0, 0, -1);
      end
      run_pixel(0, 2'b01, 8'h00, 8'h00, 8'h00, 10, 0, 0, '0, 0, -1);
      run_pixel(0, 2'b00, 8'h00, 8'h00, 8'h00, 10, 0, 0, '0, 0, -1);
      for (int ch = 0; ch < 3; ch++) begin
         check($sformatf("lane%0d_line_dc_within_8", ch),
               {31'd0, (line_disp[ch] <= 8) && (line_disp[ch] >= -8)}, 1);
      end

      // Misaligned pixel_clk: early rise (7 cycles), then a 20-cycle low phase.
      run_pixel(1, 2'b00, 8'h12, 8'h9C, 8'hE7, 10, 0, 0, '0, 0, -1);
      run_pixel(1, 2'b00, 8'h3D, 8'h00, 8'hC8, 7, 0, 0, '0, 0, -1);
      run_pixel(1, 2'b00, 8'hA5, 8'h6B, 8'h2F, 10, 0, 0, '0, 0, -1);
      run_pixel(1, 2'b00, 8'h81, 8'hFE, 8'h40, 25, 0, 0, '0, 0, -1);
      run_pixel(0, 2'b00, 8'h00, 8'h00, 8'h00, 10, 0, 0, '0, 0, -1);
      run_pixel(0, 2'b00, 8'h00, 8'h00, 8'h00, 10, 0, 0, '0, 0, -1);

      // Reset in the middle of a character, then resume.
      run_pixel(1, 2'b00, 8'h77, 8'h88, 8'h99, 10, 0, 0, '0, 0, 4);
      run_pixel(1, 2'b00, 8'h00, 8'h00, 8'h00, 10, 0, 1, 10'h100, -8, -1);
      run_pixel(1, 2'b00, 8'hC0, 8'h0C, 8'h00, 10, 0, 0, '0, 0, -1);
      run_pixel(0, 2'b00, 8'h00, 8'h00, 8'h00, 10, 0, 0, '0, 0, -1);
      run_pixel(0, 2'b00, 8'h00, 8'h00, 8'h00, 10, 0, 0, '0, 0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
